// File: rtl/alarm_pkg.sv
// Shared types and constants for the home-alarm sequencer.
package alarm_pkg;

  localparam int unsigned SYM_W    = 2;
  localparam int unsigned CODE_LEN = 4;
  localparam int unsigned CODE_W   = SYM_W * CODE_LEN;

  localparam logic [1:0] RES_OK    = 2'd0;
  localparam logic [1:0] RES_ERROR = 2'd2;
  localparam logic [1:0] RES_NOKEY = 2'd3;

  typedef enum logic [2:0] {
    S_DISARMED  = 3'd0,
    S_EXIT_DLY  = 3'd1,
    S_ARMED     = 3'd2,
    S_ENTRY_DLY = 3'd3,
    S_ALARM     = 3'd4,
    S_PROG      = 3'd5
  } state_t;

endpackage

// File: rtl/alarm_code_collector.sv
// Keypad entry collector: captures CODE_LEN symbols, discards stale partial
// entries, compares a full entry one cycle later and reports the outcome.
module alarm_code_collector
  import alarm_pkg::*;
#(
  parameter int unsigned SYM_TIMEOUT = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              sym_valid,
  input  logic [SYM_W-1:0]  sym,
  input  logic [CODE_W-1:0] code,
  input  logic              prog_mode,
  output logic              code_ok_c,
  output logic              code_err_c,
  output logic              entry_done_c,
  output logic              timeout_c,
  output logic [CODE_W-1:0] entry_c,
  output logic [1:0]        result
);

  localparam int unsigned CNT_W = $clog2(CODE_LEN + 1);
  localparam int unsigned IDX_W = $clog2(CODE_LEN);
  localparam int unsigned TO_W  = $clog2(SYM_TIMEOUT + 1);

  logic [CNT_W-1:0]               cnt_q, cnt_d, cnt_nxt_c;
  logic [IDX_W-1:0]               idx_c;
  logic [CODE_LEN-1:0][SYM_W-1:0] sym_q, sym_d;
  logic [TO_W-1:0]                to_q, to_d;
  logic [1:0]                     result_q, result_d;
  logic                           full_c, partial_c;

  assign full_c    = (cnt_q == CNT_W'(CODE_LEN));
  assign partial_c = (cnt_q != '0) && !full_c;
  assign entry_c   = sym_q;
  assign result    = result_q;

  // Compare a full entry, age a partial one, and append accepted symbols.
  always_comb begin
    cnt_d        = cnt_q;
    sym_d        = sym_q;
    to_d         = to_q;
    result_d     = result_q;
    idx_c        = cnt_q[IDX_W-1:0];
    cnt_nxt_c    = cnt_q + CNT_W'(1);
    code_ok_c    = 1'b0;
    code_err_c   = 1'b0;
    entry_done_c = 1'b0;
    timeout_c    = 1'b0;
    if (full_c) begin
      cnt_d     = '0;
      idx_c     = '0;
      cnt_nxt_c = CNT_W'(1);
      if (prog_mode) begin
        entry_done_c = 1'b1;
        result_d     = RES_OK;
      end else if (sym_q == code) begin
        code_ok_c = 1'b1;
        result_d  = RES_OK;
      end else begin
        code_err_c = 1'b1;
        result_d   = RES_ERROR;
      end
    end
    if (sym_valid) begin
      sym_d[idx_c] = sym;
      cnt_d        = cnt_nxt_c;
      result_d     = RES_NOKEY;
      to_d         = (cnt_nxt_c == CNT_W'(CODE_LEN)) ? '0 : TO_W'(SYM_TIMEOUT);
    end else if (partial_c && tick && (to_q != '0)) begin
      if (to_q == TO_W'(1)) begin
        timeout_c = 1'b1;
        cnt_d     = '0;
        to_d      = '0;
        result_d  = RES_NOKEY;
      end else begin
        to_d = to_q - TO_W'(1);
      end
    end
  end

  // Entry state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sym_q    <= '0;
      to_q     <= '0;
      result_q <= RES_NOKEY;
    end else begin
      cnt_q    <= cnt_d;
      sym_q    <= sym_d;
      to_q     <= to_d;
      result_q <= result_d;
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Home-alarm sequencer: arm/disarm FSM, delay timers, failed-code lockout.
// Optional code programming is built when ALARM_CODE_CHANGE_EN is defined.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter logic [CODE_W-1:0] DEFAULT_CODE = 8'h00,
  parameter int unsigned       EXIT_DLY     = 10,
  parameter int unsigned       ENTRY_DLY    = 10,
  parameter int unsigned       SIREN_TIME   = 60,
  parameter int unsigned       MAX_FAIL     = 3,
  parameter int unsigned       LOCK_TIME    = 30,
  parameter int unsigned       SYM_TIMEOUT  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym,
  input  logic             sensor,
  input  logic             prog_req,
  output logic             armed,
  output logic             siren,
  output logic             lockout,
  output logic [1:0]       result
);

  localparam int unsigned DLY_A   = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
  localparam int unsigned MAX_DLY = (SIREN_TIME > DLY_A) ? SIREN_TIME : DLY_A;
  localparam int unsigned TMR_W   = $clog2(MAX_DLY + 1);
  localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int unsigned LOCK_W  = $clog2(LOCK_TIME + 1);

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;
  logic                armed_q, armed_d, siren_q, siren_d, lockout_q, lockout_d;
  logic                code_ok_c, code_err_c, entry_done_c, timeout_c;
  logic                lock_trip_c, expire_c, sym_acc_c, prog_mode_c;
  logic [CODE_W-1:0]   code_c, entry_c;

  assign armed     = armed_q;
  assign siren     = siren_q;
  assign lockout   = lockout_q;
  assign sym_acc_c = sym_valid && !lockout_q;
  assign expire_c  = tick && (tmr_q == TMR_W'(1));

  alarm_code_collector #(
    .SYM_TIMEOUT (SYM_TIMEOUT)
  ) u_collector (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .sym_valid    (sym_acc_c),
    .sym          (sym),
    .code         (code_c),
    .prog_mode    (prog_mode_c),
    .code_ok_c    (code_ok_c),
    .code_err_c   (code_err_c),
    .entry_done_c (entry_done_c),
    .timeout_c    (timeout_c),
    .entry_c      (entry_c),
    .result       (result)
  );

`ifdef ALARM_CODE_CHANGE_EN
  logic [CODE_W-1:0] code_q, code_d;

  assign code_c      = code_q;
  assign prog_mode_c = (state_q == S_PROG);

  // A completed programming entry replaces the stored code.
  always_comb begin
    code_d = code_q;
    if (entry_done_c) code_d = entry_c;
  end

  // Stored code register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) code_q <= DEFAULT_CODE;
    else        code_q <= code_d;
  end
`else
  logic unused_cfg;

  assign code_c      = DEFAULT_CODE;
  assign prog_mode_c = 1'b0;
  assign unused_cfg  = ^{prog_req, entry_done_c, entry_c, timeout_c};
`endif

  // Consecutive wrong-code counting and lockout timer.
  always_comb begin
    fail_d      = fail_q;
    lock_d      = lock_q;
    lock_trip_c = 1'b0;
    if (code_ok_c) begin
      fail_d = '0;
    end else if (code_err_c) begin
      if (fail_q == FAIL_W'(MAX_FAIL - 1)) begin
        fail_d      = '0;
        lock_d      = LOCK_W'(LOCK_TIME);
        lock_trip_c = 1'b1;
      end else begin
        fail_d = fail_q + FAIL_W'(1);
      end
    end
    if (!lock_trip_c && tick && (lock_q != '0)) lock_d = lock_q - LOCK_W'(1);
    lockout_d = (lock_d != '0);
  end

  // Arm/disarm next state, state timer reload/countdown, derived outputs.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_DISARMED: begin
        if (code_ok_c) begin
`ifdef ALARM_CODE_CHANGE_EN
          state_d = prog_req ? S_PROG : S_EXIT_DLY;
`else
          state_d = S_EXIT_DLY;
`endif
        end
      end
      S_EXIT_DLY: begin
        if (code_ok_c)     state_d = S_DISARMED;
        else if (expire_c) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (code_ok_c)        state_d = S_DISARMED;
        else if (lock_trip_c) state_d = S_ALARM;
        else if (sensor)      state_d = S_ENTRY_DLY;
      end
      S_ENTRY_DLY: begin
        if (code_ok_c)                    state_d = S_DISARMED;
        else if (lock_trip_c || expire_c) state_d = S_ALARM;
      end
      S_ALARM: begin
        if (code_ok_c)     state_d = S_DISARMED;
        else if (expire_c) state_d = S_ARMED;
      end
`ifdef ALARM_CODE_CHANGE_EN
      S_PROG: begin
        if (entry_done_c || timeout_c) state_d = S_DISARMED;
      end
`endif
      default: state_d = S_DISARMED;
    endcase
    if (state_d != state_q) begin
      case (state_d)
        S_EXIT_DLY:  tmr_d = TMR_W'(EXIT_DLY);
        S_ENTRY_DLY: tmr_d = TMR_W'(ENTRY_DLY);
        S_ALARM:     tmr_d = TMR_W'(SIREN_TIME);
        default:     tmr_d = '0;
      endcase
    end else if (tick && (tmr_q != '0)) begin
      tmr_d = tmr_q - TMR_W'(1);
    end
    armed_d = (state_d == S_ARMED) || (state_d == S_ENTRY_DLY) || (state_d == S_ALARM);
    siren_d = (state_d == S_ALARM);
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_DISARMED;
      tmr_q     <= '0;
      fail_q    <= '0;
      lock_q    <= '0;
      armed_q   <= 1'b0;
      siren_q   <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      fail_q    <= fail_d;
      lock_q    <= lock_d;
      armed_q   <= armed_d;
      siren_q   <= siren_d;
      lockout_q <= lockout_d;
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus random traffic, every
// cycle compared against a behavioural model of the alarm rules.
module tb_alarm_controller;

  localparam int M_DIS = 0, M_EXIT = 1, M_ARMED = 2, M_ENTRY = 3, M_ALARM = 4, M_PROG = 5;
  localparam int T_EXIT = 10, T_ENTRY = 10, T_SIREN = 60, N_FAIL = 3, T_LOCK = 30, T_SYM = 5;
`ifdef ALARM_CODE_CHANGE_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, tick, sym_valid, sensor, prog_req;
  logic [1:0] sym, result;
  logic       armed, siren, lockout;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int m_mode, m_elapsed, m_fails, m_lock, m_idle, m_res, m_code;
  int m_entry[$];
  bit m_pending;

  alarm_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .sym_valid (sym_valid),
    .sym       (sym),
    .sensor    (sensor),
    .prog_req  (prog_req),
    .armed     (armed),
    .siren     (siren),
    .lockout   (lockout),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int dur(input int m);
    case (m)
      M_EXIT:  return T_EXIT;
      M_ENTRY: return T_ENTRY;
      M_ALARM: return T_SIREN;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_DIS; m_elapsed = 0; m_fails = 0; m_lock = 0;
    m_idle = 0; m_res = 3; m_code = 0; m_pending = 1'b0;
    m_entry.delete();
  endtask

  // One clock edge of the alarm rules, applied to the inputs seen at that edge.
  task automatic model_step(input bit tk, input bit sv, input bit [1:0] s, input bit sen, input bit pr);
    bit ok = 0, err = 0, done = 0, tmo = 0, trip = 0, expire, sv_eff;
    int nxt, val = 0;
    sv_eff = sv && (m_lock == 0);
    if (m_pending) begin
      foreach (m_entry[i]) val += m_entry[i] << (2 * i);
      if (m_mode == M_PROG) begin done = 1; m_res = 0; end
      else if (val == m_code) begin ok = 1; m_res = 0; end
      else begin err = 1; m_res = 2; end
      m_entry.delete();
      m_pending = 1'b0;
    end
    if (sv_eff) begin
      m_entry.push_back(int'(s));
      m_idle = 0;
      m_res  = 3;
      if (m_entry.size() == 4) m_pending = 1'b1;
    end else if (m_entry.size() > 0 && tk) begin
      m_idle++;
      if (m_idle == T_SYM) begin tmo = 1; m_entry.delete(); m_res = 3; end
    end
    if (ok) m_fails = 0;
    else if (err) begin
      if (m_fails + 1 == N_FAIL) begin m_fails = 0; m_lock = T_LOCK; trip = 1; end
      else m_fails++;
    end
    if (!trip && tk && m_lock > 0) m_lock--;
    expire = tk && dur(m_mode) > 0 && m_elapsed == dur(m_mode) - 1;
    nxt = m_mode;
    case (m_mode)
      M_DIS:   if (ok) nxt = (PROG_EN && pr) ? M_PROG : M_EXIT;
      M_EXIT:  if (ok) nxt = M_DIS; else if (expire) nxt = M_ARMED;
      M_ARMED: if (ok) nxt = M_DIS; else if (trip) nxt = M_ALARM; else if (sen) nxt = M_ENTRY;
      M_ENTRY: if (ok) nxt = M_DIS; else if (trip || expire) nxt = M_ALARM;
      M_ALARM: if (ok) nxt = M_DIS; else if (expire) nxt = M_ARMED;
      M_PROG:  if (done) begin m_code = val; nxt = M_DIS; end else if (tmo) nxt = M_DIS;
      default: nxt = M_DIS;
    endcase
    if (nxt != m_mode) m_elapsed = 0;
    else if (tk && dur(m_mode) > 0) m_elapsed++;
    m_mode = nxt;
  endtask

  task automatic compare_all();
    check("armed",   32'(armed),   32'(m_mode == M_ARMED || m_mode == M_ENTRY || m_mode == M_ALARM));
    check("siren",   32'(siren),   32'(m_mode == M_ALARM));
    check("lockout", 32'(lockout), 32'(m_lock > 0));
    check("result",  32'(result),  32'(m_res));
  endtask

  // Drive one cycle (from a falling edge), advance the model, compare.
  task automatic step(input bit tk, input bit sv, input bit [1:0] s, input bit sen);
    tick = tk; sym_valid = sv; sym = s; sensor = sen;
    @(posedge clk);
    model_step(tk, sv, s, sen, prog_req);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic send_sym(input bit [1:0] s);
    step(1'b0, 1'b1, s, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic enter_code(input bit [7:0] c);
    for (int i = 0; i < 4; i++) send_sym(c[2*i +: 2]);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 2'd0, 1'b0);
      step(1'b0, 1'b0, 2'd0, 1'b0);
    end
  endtask

  function automatic bit rtick();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic rand_syms(input int n, input bit [7:0] c, input bit use_code);
    bit [1:0] s;
    for (int i = 0; i < n; i++) begin
      s = use_code ? c[2*i +: 2] : 2'($urandom_range(0, 3));
      step(rtick(), 1'b1, s, 1'b0);
      repeat ($urandom_range(0, 2)) step(rtick(), 1'b0, 2'd0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; sym_valid = 1'b0; sym = 2'd0; sensor = 1'b0; prog_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_siren", 32'(siren), 32'd0);
    check("rst_lockout", 32'(lockout), 32'd0);
    check("rst_result", 32'(result), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;

    // Arm with the default code, exit delay runs out on the 10th tick.
    enter_code(8'h00);
    check("t1_result", 32'(result), 32'd0);
    wait_ticks(9);
    check("t1_armed_early", 32'(armed), 32'd0);
    wait_ticks(1);
    check("t1_armed", 32'(armed), 32'd1);
    check("t1_siren", 32'(siren), 32'd0);

    // Sensor trip, entry delay expires, then disarm.
    step(1'b0, 1'b0, 2'd0, 1'b1);
    wait_ticks(9);
    check("t2_siren_early", 32'(siren), 32'd0);
    wait_ticks(1);
    check("t2_siren", 32'(siren), 32'd1);
    enter_code(8'h00);
    check("t2_siren_off", 32'(siren), 32'd0);
    check("t2_disarmed", 32'(armed), 32'd0);

    // Three wrong codes while armed: lockout and alarm.
    enter_code(8'h00);
    wait_ticks(10);
    for (int k = 0; k < 3; k++) begin
      enter_code(8'h39);
      check("t3_err", 32'(result), 32'd2);
    end
    check("t3_lockout", 32'(lockout), 32'd1);
    check("t3_siren", 32'(siren), 32'd1);
    enter_code(8'h00);
    check("t3_ignored", 32'(result), 32'd2);
    wait_ticks(29);
    check("t3_lock_held", 32'(lockout), 32'd1);
    wait_ticks(1);
    check("t3_lock_end", 32'(lockout), 32'd0);
    enter_code(8'h00);
    check("t3_disarm", 32'(siren), 32'd0);

    // Inactivity timeout on partial entries (4 ticks survive, 5 discard).
    send_sym(2'd0); send_sym(2'd0);
    wait_ticks(4);
    send_sym(2'd0); send_sym(2'd0);
    check("t4_no_timeout", 32'(result), 32'd0);
    send_sym(2'd0); send_sym(2'd0);
    wait_ticks(5);
    send_sym(2'd0); send_sym(2'd0);
    check("t4_timeout", 32'(result), 32'd3);
    send_sym(2'd0); send_sym(2'd0);
    check("t4_fresh", 32'(result), 32'd0);
    check("t4_cancel", 32'(armed), 32'd0);

`ifdef ALARM_CODE_CHANGE_EN
    // Program a new code and verify old/new codes.
    prog_req = 1'b1;
    enter_code(8'h00);
    prog_req = 1'b0;
    enter_code(8'h67);
    check("t5_prog_done", 32'(result), 32'd0);
    enter_code(8'h00);
    check("t5_old_code", 32'(result), 32'd2);
    enter_code(8'h67);
    check("t5_new_code", 32'(result), 32'd0);
    enter_code(8'h67);
`endif

    // Reset during siren with a partial entry held.
    enter_code(8'(m_code));
    wait_ticks(10);
    step(1'b0, 1'b0, 2'd0, 1'b1);
    wait_ticks(10);
    check("t6_siren", 32'(siren), 32'd1);
    send_sym(2'd1); send_sym(2'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_armed", 32'(armed), 32'd0);
    check("t6_rst_siren", 32'(siren), 32'd0);
    check("t6_rst_lockout", 32'(lockout), 32'd0);
    check("t6_rst_result", 32'(result), 32'd3);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    enter_code(8'h00);
    check("t6_fresh_entry", 32'(result), 32'd0);

    // Random traffic against the model.
    for (int ep = 0; ep < 400; ep++) begin
      case ($urandom_range(0, 4))
        0: rand_syms(4, 8'(m_code), 1'b1);
        1: rand_syms(4, 8'h00, 1'b0);
        2: rand_syms($urandom_range(1, 3), 8'h00, 1'b0);
        3: step(rtick(), 1'b0, 2'd0, 1'b1);
        default: repeat ($urandom_range(1, 40)) step(rtick(), 1'b0, 2'd0, 1'b0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
